// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared hazard controller states and PC source select codes
package core_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

endpackage

// File: rtl/lu_detect.sv
// rtl/lu_detect.sv - load-use hazard detection between the ID and EX instructions
module lu_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic             ex_valid,
    output logic             lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == ex_rd);
    assign rt_hit = id_uses_rt && (id_rt == ex_rd);
    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign lu     = ex_valid && ex_load && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - pipeline stall, freeze and flush controller for the 5-stage core
module hazard_flush_ctrl
    import core_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic                   ex_load,
    input  logic                   ex_valid,
    input  logic                   br_taken,
    input  logic                   jump,
    input  logic                   mem_busy,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic [FLUSH_DEPTH-1:0] flush,
    output logic                   bubble,
    output logic [1:0]             pc_sel,
    output logic [1:0]             hz_state
);

    localparam logic [FLUSH_DEPTH-1:0] FLUSH_ALL = {FLUSH_DEPTH{1'b1}};
    localparam logic [FLUSH_DEPTH-1:0] FLUSH_JMP = FLUSH_DEPTH'(1);
    localparam logic [2:0]             CNT_INIT  = 3'((LOAD_LATENCY > 1) ? LOAD_LATENCY - 2 : 0);

    hz_state_t  state, nxt_state, ret_state, nxt_ret, eff_state;
    logic [2:0] cnt, nxt_cnt;
    logic [1:0] pend_sel, nxt_pend;
    logic       lu;

    lu_detect #(.REG_W(REG_W)) u_lu_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_rd      (ex_rd),
        .ex_load    (ex_load),
        .ex_valid   (ex_valid),
        .lu         (lu)
    );

    always_comb begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        flush     = '0;
        bubble    = 1'b0;
        pc_sel    = PC_SEQ;
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_ret   = ret_state;
        nxt_pend  = pend_sel;
        eff_state = state;

        // On release, a parked redirect wins; otherwise the interrupted state is replayed this cycle.
        if (state == MEM_WAIT) begin
            if (mem_busy) begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
            end else if (pend_sel != PC_SEQ) begin
                pc_sel    = pend_sel;
                flush     = (pend_sel == PC_BR) ? FLUSH_ALL : FLUSH_JMP;
                nxt_pend  = PC_SEQ;
                nxt_state = RUN;
            end else begin
                eff_state = ret_state;
                nxt_state = ret_state;
            end
        end

        case (eff_state)
            RUN: begin
                if (mem_busy) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    nxt_state = MEM_WAIT;
                    nxt_ret   = RUN;
                    nxt_pend  = br_taken ? PC_BR : (jump ? PC_JMP : PC_SEQ);
                end else if (br_taken) begin
                    pc_sel = PC_BR;
                    flush  = FLUSH_ALL;
                end else if (jump) begin
                    pc_sel = PC_JMP;
                    flush  = FLUSH_JMP;
                end else if (lu) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    bubble   = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        nxt_cnt   = CNT_INIT;
                        nxt_state = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                if (mem_busy) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    nxt_state = MEM_WAIT;
                    nxt_ret   = LU_STALL;
                    nxt_pend  = br_taken ? PC_BR : PC_SEQ;
                end else if (br_taken) begin
                    pc_sel    = PC_BR;
                    flush     = FLUSH_ALL;
                    nxt_state = RUN;
                end else begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    bubble   = 1'b1;
                    if (cnt == 3'd0) nxt_state = RUN;
                    else             nxt_cnt   = cnt - 3'd1;
                end
            end
            default: ;
        endcase

        if (rst) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            flush    = FLUSH_ALL;
            bubble   = 1'b0;
            pc_sel   = PC_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 3'd0;
            pend_sel  <= PC_SEQ;
            ret_state <= RUN;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            pend_sel  <= nxt_pend;
            ret_state <= nxt_ret;
        end
    end

    assign hz_state = state;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb/tb_hazard_flush_ctrl.sv - self-checking bench for hazard_flush_ctrl
module tb_hazard_flush_ctrl;

    localparam int L = 3;
    localparam int FD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_uses_rs = 0, id_uses_rt = 0, ex_load = 0, ex_valid = 0;
    logic br_taken = 0, jump = 0, mem_busy = 0;
    logic pc_en, if_id_en, bubble;
    logic [FD-1:0] flush;
    logic [1:0] pc_sel, hz_state;

    int n_checks = 0;
    int n_pass = 0;

    // reference model: pending-stall count, frozen flag and parked redirect
    int m_left = 0, m_pend = 0, n_left, n_pend;
    bit m_wait = 0, n_wait;
    logic e_pc, e_if, e_bub;
    logic [1:0] e_fl, e_sel, e_st;
    logic [8:0] exp_v;
    wire  [8:0] obs = {pc_en, if_id_en, flush, bubble, pc_sel, hz_state};

    hazard_flush_ctrl #(.REG_W(5), .LOAD_LATENCY(L), .FLUSH_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
        .ex_load(ex_load), .ex_valid(ex_valid), .br_taken(br_taken),
        .jump(jump), .mem_busy(mem_busy), .pc_en(pc_en), .if_id_en(if_id_en),
        .flush(flush), .bubble(bubble), .pc_sel(pc_sel), .hz_state(hz_state)
    );

    always #5 clk = ~clk;

    task automatic redirect(input int kind);
        e_sel = 2'(kind);
        e_fl  = (kind == 1) ? 2'b11 : 2'b01;
    endtask

    task automatic model_eval();
        bit lu, normal;
        lu = ex_valid && ex_load && ex_rd != 0 &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        e_pc = 1; e_if = 1; e_fl = 0; e_bub = 0; e_sel = 0;
        e_st = m_wait ? 2'd2 : (m_left > 0 ? 2'd1 : 2'd0);
        n_wait = m_wait; n_pend = m_pend; n_left = m_left;
        normal = 1;
        if (rst) begin
            e_pc = 0; e_if = 0; e_fl = 2'b11;
            n_wait = 0; n_pend = 0; n_left = 0;
            normal = 0;
        end else if (m_wait) begin
            if (mem_busy) begin
                e_pc = 0; e_if = 0; normal = 0;
            end else begin
                n_wait = 0;
                if (m_pend != 0) begin
                    redirect(m_pend); n_pend = 0; n_left = 0; normal = 0;
                end
            end
        end
        if (normal) begin
            if (mem_busy) begin
                e_pc = 0; e_if = 0; n_wait = 1;
                n_pend = br_taken ? 1 : ((jump && m_left == 0) ? 2 : 0);
            end else if (br_taken) begin
                redirect(1); n_left = 0;
            end else if (m_left > 0) begin
                e_pc = 0; e_if = 0; e_bub = 1; n_left = m_left - 1;
            end else if (jump) begin
                redirect(2);
            end else if (lu) begin
                e_pc = 0; e_if = 0; e_bub = 1; n_left = L - 1;
            end
        end
        exp_v = {e_pc, e_if, e_fl, e_bub, e_sel, e_st};
    endtask

    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_wait = n_wait; m_pend = n_pend; m_left = n_left;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_load = 0; ex_valid = 0; br_taken = 0; jump = 0; mem_busy = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if (obs !== exp_v || flush !== 2'b11 || pc_en !== 1'b0)
                $display("FAIL reset_hold[%0d]: got %b required %b", i, obs, exp_v);
            else n_pass++;
            advance();
        end
        rst = 0;
        settle();
        n_checks++;
        if (obs !== exp_v || hz_state !== 2'd0 || pc_en !== 1'b1)
            $display("FAIL reset_release: got %b required %b", obs, exp_v);
        else n_pass++;
        advance();
    endtask

    task automatic test_load_use();
        idle_inputs();
        ex_valid = 1; ex_load = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
        for (int i = 0; i < L + 1; i++) begin
            settle();
            n_checks++;
            if (obs !== exp_v || pc_en !== (i >= L) || bubble !== (i < L))
                $display("FAIL load_use[%0d]: got %b required %b", i, obs, exp_v);
            else n_pass++;
            advance();
            ex_load = 0;
        end
        ex_load = 1; ex_rd = 0; id_rs = 0;
        settle();
        n_checks++;
        if (obs !== exp_v || pc_en !== 1'b1 || bubble !== 1'b0)
            $display("FAIL load_use_r0: got %b required %b", obs, exp_v);
        else n_pass++;
        advance();
        idle_inputs();
    endtask

    task automatic test_br_jump_same();
        idle_inputs();
        br_taken = 1; jump = 1;
        settle();
        n_checks++;
        if (obs !== exp_v || pc_sel !== 2'd1 || flush !== 2'b11)
            $display("FAIL br_jump_same: got %b required %b", obs, exp_v);
        else n_pass++;
        advance();
        idle_inputs();
        settle();
        n_checks++;
        if (obs !== exp_v || flush !== 2'b00 || pc_sel !== 2'd0)
            $display("FAIL br_jump_after: got %b required %b", obs, exp_v);
        else n_pass++;
        advance();
    endtask

    task automatic test_mem_in_stall();
        logic [2:0] want_pc;
        idle_inputs();
        ex_valid = 1; ex_load = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1;
        // cycle 0 detect, 1-4 frozen, 5-6 stall, 7 run
        for (int i = 0; i < 8; i++) begin
            mem_busy = (i >= 1 && i <= 4);
            settle();
            want_pc = {1'b0, (i == 7), (i == 0 || i == 5 || i == 6)};
            n_checks++;
            if (obs !== exp_v || pc_en !== want_pc[1] || bubble !== want_pc[0])
                $display("FAIL mem_in_stall[%0d]: got %b required %b", i, obs, exp_v);
            else n_pass++;
            advance();
            ex_load = 0;
        end
        idle_inputs();
    endtask

    task automatic test_jump_mem_busy();
        idle_inputs();
        jump = 1; mem_busy = 1;
        for (int i = 0; i < 5; i++) begin
            mem_busy = (i < 3);
            settle();
            n_checks++;
            if (obs !== exp_v ||
                flush !== ((i == 3) ? 2'b01 : 2'b00) ||
                pc_sel !== ((i == 3) ? 2'd2 : 2'd0))
                $display("FAIL jump_mem_busy[%0d]: got %b required %b", i, obs, exp_v);
            else n_pass++;
            advance();
            jump = 0;
        end
    endtask

    task automatic test_reset_pending();
        idle_inputs();
        br_taken = 1; mem_busy = 1;
        settle(); advance();
        br_taken = 0;
        settle(); advance();
        rst = 1;
        settle(); advance();
        rst = 0; mem_busy = 0;
        settle();
        n_checks++;
        if (obs !== exp_v || pc_sel !== 2'd0 || flush !== 2'b00 || hz_state !== 2'd0)
            $display("FAIL reset_pending: got %b required %b", obs, exp_v);
        else n_pass++;
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            mem_busy   = ($urandom_range(0, 4) == 0);
            br_taken   = ($urandom_range(0, 9) == 0);
            jump       = ($urandom_range(0, 7) == 0);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_load    = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 3));
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            settle();
            n_checks++;
            if (obs !== exp_v)
                $display("FAIL random[%0d]: got %b required %b", i, obs, exp_v);
            else n_pass++;
            advance();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_br_jump_same();
        test_mem_in_stall();
        test_jump_mem_busy();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
